// File: rtl/raw_hazard_unit.sv
// Read-after-write hazard detector for WISC-SP22 decode: tracks destination
// registers of EX/MEM/WB and stalls decode while a source matches one of them.
module raw_hazard_unit #(
    parameter bit WB_BYPASS = 1'b1,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [15:0]      id_instr,
    input  logic             id_valid,
    input  logic             flush,
    output logic             stall,
    output logic [3:0]       ex_dest,
    output logic [CNT_W-1:0] stall_count
);

    logic [4:0] opcode;
    logic [2:0] rs_fld;
    logic [2:0] rt_fld;
    logic [2:0] rd_fld;
    logic       src1_vld;
    logic       src2_vld;
    logic [2:0] src2_reg;
    logic       dst_vld;
    logic [2:0] dst_reg;
    logic       hazard;
    logic       unused_bits;

    logic       ex_vld_q, ex_vld_d;
    logic [2:0] ex_reg_q, ex_reg_d;
    logic       mem_vld_q;
    logic [2:0] mem_reg_q;
    logic       wb_vld_q;
    logic [2:0] wb_reg_q;
    logic [CNT_W-1:0] stall_count_q, stall_count_d;

    assign opcode      = id_instr[15:11];
    assign rs_fld      = id_instr[10:8];
    assign rt_fld      = id_instr[7:5];
    assign rd_fld      = id_instr[4:2];
    assign unused_bits = ^id_instr[1:0];

    function automatic logic slot_hit(input logic src_vld, input logic [2:0] src,
                                      input logic slot_vld, input logic [2:0] slot_reg);
        return src_vld & slot_vld & (src == slot_reg);
    endfunction

    // Decode which register fields the decode instruction reads and writes
    always_comb begin
        src1_vld = 1'b0;
        src2_vld = 1'b0;
        src2_reg = rt_fld;
        dst_vld  = 1'b0;
        dst_reg  = 3'd0;
        casez (opcode)
            5'b010??, 5'b101??, 5'b10001: begin
                src1_vld = 1'b1;
                dst_vld  = 1'b1;
                dst_reg  = rt_fld;
            end
            5'b10000: begin
                src1_vld = 1'b1;
                src2_vld = 1'b1;
            end
            5'b10011: begin
                src1_vld = 1'b1;
                src2_vld = 1'b1;
                dst_vld  = 1'b1;
                dst_reg  = rs_fld;
            end
            5'b10010: begin
                src1_vld = 1'b1;
                dst_vld  = 1'b1;
                dst_reg  = rs_fld;
            end
            5'b11001: begin
                src1_vld = 1'b1;
                dst_vld  = 1'b1;
                dst_reg  = rd_fld;
            end
            5'b1101?, 5'b111??: begin
                src1_vld = 1'b1;
                src2_vld = 1'b1;
                dst_vld  = 1'b1;
                dst_reg  = rd_fld;
            end
            5'b011??, 5'b00101: begin
                src1_vld = 1'b1;
            end
            5'b11000: begin
                dst_vld = 1'b1;
                dst_reg = rs_fld;
            end
            5'b00110: begin
                dst_vld = 1'b1;
                dst_reg = 3'd7;
            end
            5'b00111: begin
                src1_vld = 1'b1;
                dst_vld  = 1'b1;
                dst_reg  = 3'd7;
            end
            default: begin
                src1_vld = 1'b0;
                src2_vld = 1'b0;
                dst_vld  = 1'b0;
            end
        endcase
    end

    // Compare decode sources against every live slot; flush and reset mask the result
    always_comb begin
        hazard = slot_hit(src1_vld, rs_fld, ex_vld_q, ex_reg_q)
               | slot_hit(src2_vld, src2_reg, ex_vld_q, ex_reg_q)
               | slot_hit(src1_vld, rs_fld, mem_vld_q, mem_reg_q)
               | slot_hit(src2_vld, src2_reg, mem_vld_q, mem_reg_q);
        if (WB_BYPASS == 1'b0) begin
            hazard = hazard
                   | slot_hit(src1_vld, rs_fld, wb_vld_q, wb_reg_q)
                   | slot_hit(src2_vld, src2_reg, wb_vld_q, wb_reg_q);
        end else begin
            hazard = hazard;
        end
        stall = hazard & id_valid & ~flush & ~rst;
    end

    // Next EX slot contents and saturating stall counter
    always_comb begin
        ex_vld_d      = 1'b0;
        ex_reg_d      = 3'd0;
        stall_count_d = stall_count_q;
        if (rst || stall || flush || !id_valid || !dst_vld) begin
            ex_vld_d = 1'b0;
            ex_reg_d = 3'd0;
        end else begin
            ex_vld_d = 1'b1;
            ex_reg_d = dst_reg;
        end
        if (stall && (stall_count_q != {CNT_W{1'b1}})) begin
            stall_count_d = stall_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            stall_count_d = stall_count_q;
        end
    end

    // Destination-tracking shift pipeline EX -> MEM -> WB
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_vld_q      <= 1'b0;
            ex_reg_q      <= 3'd0;
            mem_vld_q     <= 1'b0;
            mem_reg_q     <= 3'd0;
            wb_vld_q      <= 1'b0;
            wb_reg_q      <= 3'd0;
            stall_count_q <= {CNT_W{1'b0}};
        end else begin
            ex_vld_q      <= ex_vld_d;
            ex_reg_q      <= ex_reg_d;
            mem_vld_q     <= ex_vld_q;
            mem_reg_q     <= ex_reg_q;
            wb_vld_q      <= mem_vld_q;
            wb_reg_q      <= mem_reg_q;
            stall_count_q <= stall_count_d;
        end
    end

    assign ex_dest     = {ex_vld_q, ex_reg_q};
    assign stall_count = stall_count_q;

endmodule

// File: tb/tb_raw_hazard_unit.sv
// Directed bench for raw_hazard_unit: a vector table on a WB_BYPASS=1 instance
// and a saturation sequence on a narrow-counter WB_BYPASS=0 instance.
module tb_raw_hazard_unit;

    logic        clk = 1'b0;
    logic        rst, id_valid, flush, stall;
    logic [15:0] id_instr;
    logic [3:0]  ex_dest;
    logic [15:0] stall_count;

    logic        rst_b, stall_b;
    logic [15:0] instr_b;
    logic [3:0]  ex_dest_b;
    logic [3:0]  cnt_b;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    raw_hazard_unit #(.WB_BYPASS(1'b1), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .id_instr(id_instr), .id_valid(id_valid),
        .flush(flush), .stall(stall), .ex_dest(ex_dest), .stall_count(stall_count)
    );

    raw_hazard_unit #(.WB_BYPASS(1'b0), .CNT_W(4)) dut_b (
        .clk(clk), .rst(rst_b), .id_instr(instr_b), .id_valid(1'b1),
        .flush(1'b0), .stall(stall_b), .ex_dest(ex_dest_b), .stall_count(cnt_b)
    );

    typedef struct {
        logic [15:0] instr;
        logic        vld;
        logic        fl;
        logic        rs;
        logic        exp_stall;
        logic [3:0]  exp_ex;
        logic [15:0] exp_cnt;
    } vec_t;

    localparam int NV = 30;
    vec_t tbl [NV];

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    initial begin
        // instr, valid, flush, rst | stall, ex_dest, stall_count (ex/cnt as seen before this cycle's edge)
        tbl[0]  = '{16'h4025, 1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 16'd0};
        tbl[1]  = '{16'h4025, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 16'd0};
        tbl[2]  = '{16'hD928, 1'b1, 1'b0, 1'b0, 1'b1, 4'h9, 16'd0};
        tbl[3]  = '{16'hD928, 1'b1, 1'b0, 1'b0, 1'b1, 4'h0, 16'd1};
        tbl[4]  = '{16'hD928, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 16'd2};
        tbl[5]  = '{16'h4025, 1'b1, 1'b0, 1'b0, 1'b0, 4'hA, 16'd2};
        tbl[6]  = '{16'h8220, 1'b1, 1'b0, 1'b0, 1'b1, 4'h9, 16'd2};
        tbl[7]  = '{16'h8220, 1'b1, 1'b0, 1'b0, 1'b1, 4'h0, 16'd3};
        tbl[8]  = '{16'h8220, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 16'd4};
        tbl[9]  = '{16'hDA2C, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 16'd4};
        tbl[10] = '{16'h3000, 1'b1, 1'b0, 1'b0, 1'b0, 4'hB, 16'd4};
        tbl[11] = '{16'h2F00, 1'b1, 1'b0, 1'b0, 1'b1, 4'hF, 16'd4};
        tbl[12] = '{16'h2F00, 1'b1, 1'b0, 1'b0, 1'b1, 4'h0, 16'd5};
        tbl[13] = '{16'h2F00, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 16'd6};
        tbl[14] = '{16'h3000, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 16'd6};
        tbl[15] = '{16'h2000, 1'b1, 1'b0, 1'b0, 1'b0, 4'hF, 16'd6};
        tbl[16] = '{16'h2F00, 1'b1, 1'b0, 1'b0, 1'b1, 4'h0, 16'd6};
        tbl[17] = '{16'h2F00, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 16'd7};
        tbl[18] = '{16'h4025, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 16'd7};
        tbl[19] = '{16'hD928, 1'b1, 1'b1, 1'b0, 1'b0, 4'h9, 16'd7};
        tbl[20] = '{16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 16'd7};
        tbl[21] = '{16'h4025, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 16'd7};
        tbl[22] = '{16'hD928, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 16'd7};
        tbl[23] = '{16'hC000, 1'b1, 1'b0, 1'b0, 1'b0, 4'hA, 16'd7};
        tbl[24] = '{16'h4025, 1'b1, 1'b0, 1'b0, 1'b1, 4'h8, 16'd7};
        tbl[25] = '{16'h4025, 1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 16'd8};
        tbl[26] = '{16'h4025, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 16'd0};
        tbl[27] = '{16'hC90C, 1'b1, 1'b0, 1'b0, 1'b1, 4'h9, 16'd0};
        tbl[28] = '{16'hC90C, 1'b1, 1'b0, 1'b0, 1'b1, 4'h0, 16'd1};
        tbl[29] = '{16'hC90C, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 16'd2};

        rst = 1'b1; id_valid = 1'b0; flush = 1'b0; id_instr = 16'h0000;
        rst_b = 1'b1; instr_b = 16'h0000;
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < NV; i++) begin
            id_instr = tbl[i].instr;
            id_valid = tbl[i].vld;
            flush    = tbl[i].fl;
            rst      = tbl[i].rs;
            @(negedge clk);
            chk("stall", i, {31'd0, stall}, {31'd0, tbl[i].exp_stall});
            chk("ex_dest", i, {28'd0, ex_dest}, {28'd0, tbl[i].exp_ex});
            chk("stall_count", i, {16'd0, stall_count}, {16'd0, tbl[i].exp_cnt});
            @(posedge clk);
            #1;
        end

        // WB_BYPASS=0: each ADDI R1 / ADD R2,R1,R1 pair stalls three cycles; 4-bit counter saturates
        rst_b = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            instr_b = 16'h4025;
            @(negedge clk);
            chk("b_addi_stall", k, {31'd0, stall_b}, 32'd0);
            @(posedge clk);
            #1;
            for (int c = 0; c < 4; c++) begin
                instr_b = 16'hD928;
                @(negedge clk);
                chk("b_add_stall", k * 10 + c, {31'd0, stall_b}, (c < 3) ? 32'd1 : 32'd0);
                if (c == 3) begin
                    chk("b_count", k, {28'd0, cnt_b}, (3 * k > 15) ? 32'd15 : 32'(3 * k));
                end
                @(posedge clk);
                #1;
            end
        end
        chk("b_count_hold", 0, {28'd0, cnt_b}, 32'd15);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
